// File: rtl/hazard_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
//   hz_state_e  : controller FSM states (RUN, LOAD_BUB, MEM_WAIT, ABORT)
//   pipe_ctrl_t : the seven stall/flush enables driven to the pipeline registers
//   CTRL_*      : canned stall/flush patterns used by the FSM
package hazard_pkg;

  localparam int unsigned REG_W_DEF  = 4;
  localparam int unsigned PC_REG_DEF = 15;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LOAD_BUB = 2'd1,
    MEM_WAIT = 2'd2,
    ABORT    = 2'd3
  } hz_state_e;

  typedef struct packed {
    logic pc_stall;
    logic ifid_stall;
    logic idex_stall;
    logic exmem_stall;
    logic ifid_flush;
    logic idex_flush;
    logic memwb_flush;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CTRL_NONE = '0;

  // Whole front of the pipe frozen, bubble pushed into WB while MEM waits.
  localparam pipe_ctrl_t CTRL_MEM_STALL = '{
    pc_stall: 1'b1, ifid_stall: 1'b1, idex_stall: 1'b1, exmem_stall: 1'b1,
    ifid_flush: 1'b0, idex_flush: 1'b0, memwb_flush: 1'b1};

  localparam pipe_ctrl_t CTRL_BRANCH = '{
    pc_stall: 1'b0, ifid_stall: 1'b0, idex_stall: 1'b0, exmem_stall: 1'b0,
    ifid_flush: 1'b1, idex_flush: 1'b1, memwb_flush: 1'b0};

  localparam pipe_ctrl_t CTRL_LOAD_USE = '{
    pc_stall: 1'b1, ifid_stall: 1'b1, idex_stall: 1'b0, exmem_stall: 1'b0,
    ifid_flush: 1'b0, idex_flush: 1'b1, memwb_flush: 1'b0};

  localparam pipe_ctrl_t CTRL_ABORT = '{
    pc_stall: 1'b0, ifid_stall: 1'b0, idex_stall: 1'b0, exmem_stall: 1'b0,
    ifid_flush: 1'b1, idex_flush: 1'b1, memwb_flush: 1'b1};

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use hazard compare between the ID-stage sources and a
// load sitting in EX. Writes to the PC register are never a data hazard.
//   id_valid_i, id_rs1_i/id_rs2_i, id_use1_i/id_use2_i : ID instruction sources
//   ex_valid_i, ex_rd_i, ex_regw_i, ex_memread_i       : EX instruction status
//   load_use_o                                         : hazard detected
module hazard_detect
  import hazard_pkg::*;
#(
  parameter int unsigned REG_W  = REG_W_DEF,
  parameter int unsigned PC_REG = PC_REG_DEF
) (
  input  logic             id_valid_i,
  input  logic [REG_W-1:0] id_rs1_i,
  input  logic [REG_W-1:0] id_rs2_i,
  input  logic             id_use1_i,
  input  logic             id_use2_i,
  input  logic             ex_valid_i,
  input  logic [REG_W-1:0] ex_rd_i,
  input  logic             ex_regw_i,
  input  logic             ex_memread_i,
  output logic             load_use_o
);

  localparam logic [REG_W-1:0] PC_ID = REG_W'(PC_REG);

  logic src_match;

  assign src_match  = (id_use1_i & (id_rs1_i == ex_rd_i)) |
                      (id_use2_i & (id_rs2_i == ex_rd_i));

  assign load_use_o = id_valid_i & ex_valid_i & ex_memread_i & ex_regw_i &
                      (ex_rd_i != PC_ID) & src_match;

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencing controller: generates every stall/flush enable for the
// IF/ID/EX/MEM/WB registers to cover load-use, taken-branch and multi-cycle
// data-memory hazards. Outputs are combinational from state and inputs.
//   clk, rst_n                         : clock, async active-low reset
//   id_*, ex_*                         : decode / execute stage status
//   br_taken                           : branch in EX resolved taken
//   mem_req, mem_ready                 : MEM-stage access handshake
//   pc/ifid/idex/exmem_stall           : hold pipeline registers
//   ifid/idex/memwb_flush              : insert bubbles
//   mem_timeout_err                    : sticky memory-timeout abort flag
//   state_o                            : FSM state for debug
// Optional: define HAZARD_PERF_EN to add stall_cycles, flush_events and
// load_use_events saturating performance counters (CNT_W bits each).
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int unsigned REG_W       = REG_W_DEF,
  parameter int unsigned PC_REG      = PC_REG_DEF,
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use1,
  input  logic             id_use2,
  input  logic             ex_valid,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_regw,
  input  logic             ex_memread,
  input  logic             br_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             idex_stall,
  output logic             exmem_stall,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             memwb_flush,
  output logic             mem_timeout_err,
  output logic [1:0]       state_o
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events,
  output logic [CNT_W-1:0] load_use_events
`endif
);

  localparam int unsigned      TO_W     = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(MEM_TIMEOUT);
  localparam logic [TO_W-1:0]  CNT_ONE  = TO_W'(1);

  hz_state_e       state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic            err_q, err_d;
  pipe_ctrl_t      ctrl, ctrl_out;
  logic            load_use;

  hazard_detect #(
    .REG_W  (REG_W),
    .PC_REG (PC_REG)
  ) u_detect (
    .id_valid_i   (id_valid),
    .id_rs1_i     (id_rs1),
    .id_rs2_i     (id_rs2),
    .id_use1_i    (id_use1),
    .id_use2_i    (id_use2),
    .ex_valid_i   (ex_valid),
    .ex_rd_i      (ex_rd),
    .ex_regw_i    (ex_regw),
    .ex_memread_i (ex_memread),
    .load_use_o   (load_use)
  );

  assign cnt_inc = (cnt_q == TO_LIMIT) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    ctrl    = CTRL_NONE;
    unique case (state_q)
      RUN, LOAD_BUB: begin
        if (mem_req & ~mem_ready) begin
          ctrl    = CTRL_MEM_STALL;
          state_d = MEM_WAIT;
          cnt_d   = CNT_ONE;
        end else if (state_q == LOAD_BUB) begin
          state_d = RUN;
        end else if (br_taken) begin
          ctrl = CTRL_BRANCH;
        end else if (load_use) begin
          ctrl    = CTRL_LOAD_USE;
          state_d = LOAD_BUB;
        end
      end
      MEM_WAIT: begin
        if (mem_req & mem_ready) begin
          // The completing cycle is the first one where the pipe advances, so
          // the frozen EX/ID contents are resolved here exactly as in RUN;
          // a branch held across the wait is flushed now rather than lost.
          state_d = RUN;
          cnt_d   = '0;
          if (br_taken) begin
            ctrl = CTRL_BRANCH;
          end else if (load_use) begin
            ctrl    = CTRL_LOAD_USE;
            state_d = LOAD_BUB;
          end
        end else begin
          // cnt_inc counts this cycle too, so the limit equals stalled cycles.
          ctrl = CTRL_MEM_STALL;
          if (cnt_inc == TO_LIMIT) begin
            err_d   = 1'b1;
            state_d = ABORT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      ABORT: begin
        ctrl    = CTRL_ABORT;
        state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Held inputs must not leak through the combinational path during reset.
  assign ctrl_out = rst_n ? ctrl : CTRL_NONE;

  assign pc_stall        = ctrl_out.pc_stall;
  assign ifid_stall      = ctrl_out.ifid_stall;
  assign idex_stall      = ctrl_out.idex_stall;
  assign exmem_stall     = ctrl_out.exmem_stall;
  assign ifid_flush      = ctrl_out.ifid_flush;
  assign idex_flush      = ctrl_out.idex_flush;
  assign memwb_flush     = ctrl_out.memwb_flush;
  assign mem_timeout_err = err_q;
  assign state_o         = state_q;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_q, flush_q, lu_q;
  logic             flush_evt, lu_evt;

  // A load-use idex_flush always enters LOAD_BUB; every other one is a
  // branch or abort flush.
  assign flush_evt = ctrl_out.idex_flush & (state_d != LOAD_BUB);
  assign lu_evt    = rst_n & (state_d == LOAD_BUB);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
      lu_q    <= '0;
    end else begin
      if (ctrl_out.pc_stall && (stall_q != '1)) stall_q <= stall_q + 1'b1;
      if (flush_evt && (flush_q != '1))         flush_q <= flush_q + 1'b1;
      if (lu_evt && (lu_q != '1))               lu_q    <= lu_q + 1'b1;
    end
  end

  assign stall_cycles    = stall_q;
  assign flush_events    = flush_q;
  assign load_use_events = lu_q;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: directed scenarios followed by
// randomized traffic, all checked against a behavioural reference model.
module tb_hazard_controller;

  localparam int unsigned MEM_TIMEOUT = 16;

  localparam logic [6:0] C_NONE = 7'b0000000;
  localparam logic [6:0] C_MEM  = 7'b1111001;
  localparam logic [6:0] C_BR   = 7'b0000110;
  localparam logic [6:0] C_LU   = 7'b1100010;
  localparam logic [6:0] C_AB   = 7'b0000111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, id_use1, id_use2;
  logic [3:0] id_rs1, id_rs2, ex_rd;
  logic       ex_valid, ex_regw, ex_memread, br_taken, mem_req, mem_ready;
  logic       pc_stall, ifid_stall, idex_stall, exmem_stall;
  logic       ifid_flush, idex_flush, memwb_flush, mem_timeout_err;
  logic [1:0] state_o;
`ifdef HAZARD_PERF_EN
  logic [15:0] stall_cycles, flush_events, load_use_events;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: pending bubble, cycles already stalled for memory,
  // pending abort cycle and sticky error.
  bit m_bubble, m_abort, m_err;
  int m_wait;

  logic [6:0] obs_ctrl;
  logic [1:0] obs_state;
  logic       obs_err;

  hazard_controller #(
    .REG_W       (4),
    .PC_REG      (15),
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_W       (16)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_valid        (id_valid),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_use1         (id_use1),
    .id_use2         (id_use2),
    .ex_valid        (ex_valid),
    .ex_rd           (ex_rd),
    .ex_regw         (ex_regw),
    .ex_memread      (ex_memread),
    .br_taken        (br_taken),
    .mem_req         (mem_req),
    .mem_ready       (mem_ready),
    .pc_stall        (pc_stall),
    .ifid_stall      (ifid_stall),
    .idex_stall      (idex_stall),
    .exmem_stall     (exmem_stall),
    .ifid_flush      (ifid_flush),
    .idex_flush      (idex_flush),
    .memwb_flush     (memwb_flush),
    .mem_timeout_err (mem_timeout_err),
    .state_o         (state_o)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cycles    (stall_cycles),
    .flush_events    (flush_events),
    .load_use_events (load_use_events)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic bit model_lu();
    return id_valid && ex_valid && ex_memread && ex_regw && (ex_rd != 4'd15) &&
           ((id_use1 && id_rs1 == ex_rd) || (id_use2 && id_rs2 == ex_rd));
  endfunction

  function automatic void model_expect(output logic [6:0] e, output logic [1:0] es,
                                       output logic ee);
    bit lu;
    if (!rst_n) begin
      m_bubble = 0; m_abort = 0; m_err = 0; m_wait = 0;
      e = C_NONE; es = 2'd0; ee = 1'b0;
      return;
    end
    lu = model_lu();
    es = m_abort ? 2'd3 : (m_wait > 0) ? 2'd2 : m_bubble ? 2'd1 : 2'd0;
    ee = m_err;
    if (m_abort)                  e = C_AB;
    else if (m_wait > 0)          e = (mem_req && mem_ready) ? (br_taken ? C_BR : lu ? C_LU : C_NONE) : C_MEM;
    else if (mem_req && !mem_ready) e = C_MEM;
    else if (m_bubble)            e = C_NONE;
    else                          e = br_taken ? C_BR : lu ? C_LU : C_NONE;
  endfunction

  function automatic void model_update();
    bit lu;
    if (!rst_n) return;
    lu = model_lu();
    if (m_abort) m_abort = 0;
    else if (m_wait > 0) begin
      if (mem_req && mem_ready) begin
        m_wait = 0;
        m_bubble = !br_taken && lu;
      end else begin
        m_wait++;
        if (m_wait == MEM_TIMEOUT) begin
          m_wait = 0; m_abort = 1; m_err = 1;
        end
      end
    end else if (mem_req && !mem_ready) begin
      m_wait = 1; m_bubble = 0;
    end else if (m_bubble) m_bubble = 0;
    else m_bubble = !br_taken && lu;
  endfunction

  // Called just after a negedge with inputs already driven.
  task automatic step(input string tag);
    logic [6:0] e;
    logic [1:0] es;
    logic       ee;
    #1;
    model_expect(e, es, ee);
    obs_ctrl  = {pc_stall, ifid_stall, idex_stall, exmem_stall, ifid_flush, idex_flush, memwb_flush};
    obs_state = state_o;
    obs_err   = mem_timeout_err;
    chk({tag, "/ctrl"}, {1'b0, obs_ctrl}, {1'b0, e});
    chk({tag, "/state"}, {6'd0, obs_state}, {6'd0, es});
    chk({tag, "/err"}, {7'd0, obs_err}, {7'd0, ee});
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic set_idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use1 = 0; id_use2 = 0;
    ex_valid = 0; ex_rd = 0; ex_regw = 0; ex_memread = 0;
    br_taken = 0; mem_req = 0; mem_ready = 0;
  endtask

  task automatic set_load(input logic [3:0] rd, input logic [3:0] rs1, input logic u1,
                          input logic [3:0] rs2, input logic u2);
    set_idle();
    ex_valid = 1; ex_memread = 1; ex_regw = 1; ex_rd = rd;
    id_valid = 1; id_rs1 = rs1; id_use1 = u1; id_rs2 = rs2; id_use2 = u2;
  endtask

  function automatic logic [3:0] pick_reg();
    return ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
  endfunction

  initial begin
    set_idle();
    rst_n = 0;
    m_bubble = 0; m_abort = 0; m_err = 0; m_wait = 0;
    @(negedge clk);
    step("reset");
    chk("reset_ctrl_zero", {1'b0, obs_ctrl}, 8'h00);
    rst_n = 1;

    // Load-use: one stall cycle, one bubble cycle, back to RUN.
    set_load(4'd2, 4'd2, 1, 4'd0, 0);
    step("lu0");
    chk("lu0_const", {1'b0, obs_ctrl}, {1'b0, C_LU});
    set_idle();
    step("lu1");
    chk("lu1_state", {6'd0, obs_state}, 8'd1);
    step("lu2");
    chk("lu2_state", {6'd0, obs_state}, 8'd0);

    // Immediate operand and PC destination: no hazard.
    set_load(4'd2, 4'd2, 0, 4'd3, 1);
    step("imm");
    chk("imm_const", {1'b0, obs_ctrl}, 8'h00);
    set_load(4'd15, 4'd15, 1, 4'd0, 0);
    step("pcreg");
    chk("pcreg_const", {1'b0, obs_ctrl}, 8'h00);

    // Branch beats load-use.
    set_load(4'd2, 4'd2, 1, 4'd0, 0);
    br_taken = 1;
    step("br_lu");
    chk("br_lu_const", {1'b0, obs_ctrl}, {1'b0, C_BR});
    set_idle();
    step("br_lu_after");

    // Memory wait of 3 cycles with a branch held across it.
    set_idle();
    mem_req = 1; br_taken = 1;
    for (int i = 0; i < 3; i++) begin
      step("mw");
      chk("mw_const", {1'b0, obs_ctrl}, {1'b0, C_MEM});
    end
    mem_ready = 1;
    step("mw_done");
    chk("mw_done_br", {1'b0, obs_ctrl}, {1'b0, C_BR});
    set_idle();
    step("mw_idle");
    chk("mw_idle_state", {6'd0, obs_state}, 8'd0);

    // Timeout: 16 stalled cycles, one abort cycle, sticky flag.
    mem_req = 1;
    for (int i = 0; i < 16; i++) step("to_wait");
    step("to_abort");
    chk("to_abort_ctrl", {1'b0, obs_ctrl}, {1'b0, C_AB});
    chk("to_abort_err", {7'd0, obs_err}, 8'd1);
    set_idle();
    step("to_run");
    step("to_sticky");
    chk("to_sticky_err", {7'd0, obs_err}, 8'd1);

    // Reset in the middle of a wait clears everything immediately.
    mem_req = 1;
    step("rw0");
    step("rw1");
    rst_n = 0;
    step("rw_rst");
    chk("rw_rst_ctrl", {1'b0, obs_ctrl}, 8'h00);
    chk("rw_rst_err", {7'd0, obs_err}, 8'd0);
    rst_n = 1;
    set_idle();
    step("rw_idle");

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rst_n      = ($urandom_range(0, 499) != 0);
      id_valid   = ($urandom_range(0, 3) != 0);
      id_rs1     = pick_reg();
      id_rs2     = pick_reg();
      id_use1    = $urandom_range(0, 1) == 1;
      id_use2    = $urandom_range(0, 1) == 1;
      ex_valid   = ($urandom_range(0, 3) != 0);
      ex_rd      = pick_reg();
      ex_regw    = ($urandom_range(0, 3) != 0);
      ex_memread = $urandom_range(0, 1) == 1;
      br_taken   = ($urandom_range(0, 5) == 0);
      mem_req    = (m_wait > 0) ? 1'b1 : ($urandom_range(0, 5) == 0);
      mem_ready  = (i % 500 < 100) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 2) == 0);
      step("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Pipeline sequencing controller for the 5-stage ARM-style core (IF/ID/EX/MEM/WB, 16x32-bit register file, 4-bit register IDs).
- Produces all stall/flush enables for the pipeline registers. It covers the hazards the forwarding path cannot resolve: load-use, taken branches, and multi-cycle data-memory access.
- Sits beside the forwarding unit; consumes decode/execute/memory stage status.

Parameters:
- REG_W, 4, register-ID width
- PC_REG, 15, register ID never treated as a data hazard (PC)
- MEM_TIMEOUT, 16, max MEM_WAIT cycles before forced abort
- CNT_W, 16, width of perf counters (optional feature)

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID stage holds a valid instruction
- id_rs1, id_rs2  in  REG_W  ID source registers
- id_use1, id_use2  in  1  corresponding source is actually read (not immediate)
- ex_valid  in  1  EX holds a valid instruction
- ex_rd  in  REG_W  EX destination register
- ex_regw  in  1  EX writes register file
- ex_memread  in  1  EX instruction is a load
- br_taken  in  1  branch resolved taken in EX
- mem_req  in  1  MEM stage issuing data-memory access
- mem_ready  in  1  data memory completes access this cycle
- pc_stall, ifid_stall, idex_stall, exmem_stall  out  1  hold register
- ifid_flush, idex_flush, memwb_flush  out  1  insert bubble
- mem_timeout_err  out  1  sticky abort flag
- state_o  out  2  current FSM state (debug)

Behaviour:
- Reset (async, rst_n=0): state=RUN; timeout counter=0; mem_timeout_err=0; all stall/flush outputs 0. Deassertion is synchronous to clk.
- States: RUN(0), LOAD_BUB(1), MEM_WAIT(2), ABORT(3).
- load_use = id_valid & ex_valid & ex_memread & ex_regw & ex_rd!=PC_REG & ((id_use1 & id_rs1==ex_rd) | (id_use2 & id_rs2==ex_rd)).
- RUN priority, evaluated combinationally each cycle:
  - mem_req & !mem_ready: assert pc/ifid/idex/exmem stall and memwb_flush; next state MEM_WAIT; counter=1.
  - else br_taken: ifid_flush=1, idex_flush=1, no stall. load_use is ignored because the ID instruction is discarded.
  - else load_use: pc_stall=1, ifid_stall=1, idex_flush=1; next state LOAD_BUB.
  - else: all outputs 0.
- LOAD_BUB: exactly one cycle, outputs all 0, so the load has advanced to MEM and forwarding covers it. Return to RUN. mem_req & !mem_ready here is handled as in RUN. The total load-use penalty is 1 cycle.
- MEM_WAIT: hold the full stall set every cycle. The counter increments (saturating at MEM_TIMEOUT).
  - mem_ready=1: stalls drop the same cycle; go to RUN.
  - counter==MEM_TIMEOUT and !mem_ready: set mem_timeout_err; go to ABORT.
- br_taken during MEM_WAIT: EX is frozen, so br_taken stays asserted. The flush is applied on the first RUN cycle after the wait and is not lost.
- ABORT: one cycle. Assert memwb_flush, ifid_flush, idex_flush, no stalls. Go to RUN. mem_timeout_err is cleared only by reset.
- mem_ready asserted without mem_req: ignored.
- Reset mid-MEM_WAIT: immediate return to RUN with all outputs 0.
- Latency: all stall/flush outputs are combinational from state and inputs (same-cycle); state updates on the clk rising edge.

Optional Feature:
- Macro HAZARD_PERF_EN.
- Defined: adds outputs stall_cycles, flush_events, load_use_events (each CNT_W, saturating, reset 0).
  - stall_cycles increments on any cycle with pc_stall=1.
  - flush_events increments on any cycle with idex_flush=1 caused by a branch or ABORT.
  - load_use_events increments on each RUN->LOAD_BUB transition.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Package hazard_pkg holds: state enum (RUN, LOAD_BUB, MEM_WAIT, ABORT), REG_W/PC_REG defaults, and a packed struct pipe_ctrl_t bundling the seven stall/flush bits.
- Natural sub-module: hazard_detect, purely combinational load_use compare, reusable by the forwarding tests. FSM and counters stay in hazard_controller.

Test Plan:
- Load-use: ex_memread=1, ex_rd=2, id_rs1=2, id_use1=1 -> cycle0 pc_stall=ifid_stall=idex_flush=1, state->LOAD_BUB; cycle1 all 0; cycle2 RUN.
- Immediate operand: same as above but id_use2 only, with id_rs2=3 and ex_rd=2 -> no stall. PC case: ex_rd=15=id_rs1 -> no stall.
- Branch beats load-use: br_taken=1 with load_use true -> ifid_flush=idex_flush=1, pc_stall=0, state stays RUN.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles then 1 -> full stall for 3 cycles; cycle 4 no stall, RUN. With br_taken held throughout, the flush appears in cycle 4.
- Timeout: mem_req=1, mem_ready=0 for 16 cycles -> mem_timeout_err=1, one ABORT cycle with three flushes, then RUN. The flag stays 1 until rst_n=0 is pulsed; rst_n pulse mid-wait clears all outputs immediately.
- HAZARD_PERF_EN: after the above sequence, stall_cycles=1+3+16=20 and load_use_events=1, counters saturate at 2^CNT_W-1.
